// File: rtl/branch_predictor_table_scheduler.sv
// Scheduler for the single read/write port of a 2-bit saturating-counter
// branch predictor table. It sequences three kinds of traffic on that port:
// the post-reset init sweep, fetch lookups, and buffered execute feedback.
// Feedback is applied as a read-modify-write.
module branch_predictor_table_scheduler #(
   parameter int         INDEX_BITS = 11,
   parameter int         FIFO_DEPTH = 4,
   parameter logic [1:0] INIT_VALUE = 2'b10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_lk_valid,
   input  logic [INDEX_BITS-1:0] i_lk_index,
   output logic                  o_lk_ready,
   output logic                  o_lk_valid,
   output logic                  o_lk_taken,
   input  logic                  i_fb_valid,
   input  logic [INDEX_BITS-1:0] i_fb_index,
   input  logic                  i_fb_taken,
   output logic                  o_fb_ready,
   output logic                  o_tbl_en,
   output logic                  o_tbl_we,
   output logic [INDEX_BITS-1:0] o_tbl_addr,
   output logic [1:0]            o_tbl_wdata,
   input  logic [1:0]            i_tbl_rdata,
   output logic                  o_init_busy
);

   localparam int PTR_BITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_BITS = PTR_BITS + 1;

   localparam logic [1:0] ST_INIT   = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_UPD_WR = 2'd2;

   localparam logic [INDEX_BITS-1:0] LAST_IDX = '1;
   localparam logic [CNT_BITS-1:0]   FULL_CNT = CNT_BITS'(FIFO_DEPTH);

   typedef struct packed {
      logic [INDEX_BITS-1:0] index;
      logic                  taken;
   } fb_entry_t;

   logic [1:0]            state;
   logic [INDEX_BITS-1:0] sweep_cnt;
   fb_entry_t             fifo_mem [FIFO_DEPTH];
   logic [PTR_BITS-1:0]   wr_ptr, rd_ptr;
   logic [CNT_BITS-1:0]   fifo_cnt;
   logic                  lk_vld_q;

   fb_entry_t             head;
   logic                  fifo_full, fifo_empty;
   logic                  push, pop;
   logic                  lk_grant, upd_grant;
   logic [1:0]            upd_wdata;

   assign head       = fifo_mem[rd_ptr];
   assign fifo_full  = (fifo_cnt == FULL_CNT);
   assign fifo_empty = (fifo_cnt == '0);

   // A pop in the same cycle does not reopen a full buffer; ready comes
   // only from the registered count.
   assign o_fb_ready  = rst_n && !fifo_full && (state != ST_INIT);
   assign push        = i_fb_valid && o_fb_ready;
   assign o_init_busy = !rst_n || (state == ST_INIT);
   assign o_lk_ready  = lk_grant;
   assign o_lk_valid  = lk_vld_q;
   assign o_lk_taken  = i_tbl_rdata[1];

   // Port arbitration in RUN: a full buffer first, then lookups, then drain.
   always_comb begin
      lk_grant  = 1'b0;
      upd_grant = 1'b0;
      if (rst_n && state == ST_RUN) begin
         if (fifo_full)        upd_grant = 1'b1;
         else if (i_lk_valid)  lk_grant  = 1'b1;
         else if (!fifo_empty) upd_grant = 1'b1;
      end
   end

   // Saturating counter step for the read-modify-write of the head entry.
   always_comb begin
      if (head.taken) upd_wdata = (i_tbl_rdata == 2'b11) ? 2'b11 : i_tbl_rdata + 2'd1;
      else            upd_wdata = (i_tbl_rdata == 2'b00) ? 2'b00 : i_tbl_rdata - 2'd1;
   end

   // Drive the table port from the current state. The port stays quiet
   // while reset is held, so a reset during UPD_WR drops the write.
   always_comb begin
      o_tbl_en    = 1'b0;
      o_tbl_we    = 1'b0;
      o_tbl_addr  = '0;
      o_tbl_wdata = '0;
      pop         = 1'b0;
      if (rst_n) begin
         case (state)
            ST_INIT: begin
               o_tbl_en    = 1'b1;
               o_tbl_we    = 1'b1;
               o_tbl_addr  = sweep_cnt;
               o_tbl_wdata = INIT_VALUE;
            end
            ST_RUN: begin
               if (lk_grant) begin
                  o_tbl_en   = 1'b1;
                  o_tbl_addr = i_lk_index;
               end else if (upd_grant) begin
                  o_tbl_en   = 1'b1;
                  o_tbl_addr = head.index;
               end
            end
            ST_UPD_WR: begin
               o_tbl_en    = 1'b1;
               o_tbl_we    = 1'b1;
               o_tbl_addr  = head.index;
               o_tbl_wdata = upd_wdata;
               pop         = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // State machine and init sweep counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_INIT;
         sweep_cnt <= '0;
      end else begin
         case (state)
            ST_INIT: begin
               sweep_cnt <= sweep_cnt + 1'b1;
               if (sweep_cnt == LAST_IDX) state <= ST_RUN;
            end
            ST_RUN:    if (upd_grant) state <= ST_UPD_WR;
            ST_UPD_WR: state <= ST_RUN;
            default:   state <= ST_INIT;
         endcase
      end
   end

   // Feedback buffer pointers and occupancy. The pointers wrap naturally
   // because the depth is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
            2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Feedback buffer storage. It needs no reset; occupancy gates its use.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {i_fb_index, i_fb_taken};
   end

   // The lookup result appears the cycle after the grant, when read data returns.
   always_ff @(posedge clk) begin
      if (!rst_n) lk_vld_q <= 1'b0;
      else        lk_vld_q <= lk_grant;
   end

endmodule

// File: tb/tb_branch_predictor_table_scheduler.sv
// Bench for branch_predictor_table_scheduler. A behavioural single-port RAM
// stands in for the table. A monitor keeps a reference counter array and
// scoreboards lookup results and feedback writes.
module tb_branch_predictor_table_scheduler;

   localparam int         IB    = 11;
   localparam int         N_ENT = 1 << IB;
   localparam logic [1:0] INITV = 2'b10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_lk_valid = 1'b0, i_fb_valid = 1'b0, i_fb_taken = 1'b0;
   logic [IB-1:0] i_lk_index = '0, i_fb_index = '0;
   logic          o_lk_ready, o_lk_valid, o_lk_taken, o_fb_ready;
   logic          o_tbl_en, o_tbl_we, o_init_busy;
   logic [IB-1:0] o_tbl_addr;
   logic [1:0]    o_tbl_wdata;
   logic [1:0]    tbl_rdata = 2'b00;

   int checks = 0;
   int failures = 0;
   logic mon_en = 1'b0;

   logic [1:0] mem     [N_ENT];
   logic [1:0] ref_ctr [N_ENT];

   typedef struct packed {
      logic [IB-1:0] idx;
      logic          taken;
   } fb_t;

   typedef struct {
      logic          lk_v;
      logic [IB-1:0] lk_idx;
      logic          fb_v;
      logic [IB-1:0] fb_idx;
      logic          fb_t;
      logic          e_rdy, e_fbr, e_en, e_we;
      logic [IB-1:0] e_addr;
      logic [1:0]    e_wd;
   } vec_t;

   fb_t  fbq[$];
   logic lkq[$];
   vec_t vecs[$];

   fb_t        mon_h;
   logic [1:0] mon_exp;
   logic       mon_t;

   branch_predictor_table_scheduler #(
      .INDEX_BITS(IB), .FIFO_DEPTH(4), .INIT_VALUE(INITV)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_lk_valid(i_lk_valid), .i_lk_index(i_lk_index),
      .o_lk_ready(o_lk_ready), .o_lk_valid(o_lk_valid), .o_lk_taken(o_lk_taken),
      .i_fb_valid(i_fb_valid), .i_fb_index(i_fb_index), .i_fb_taken(i_fb_taken),
      .o_fb_ready(o_fb_ready),
      .o_tbl_en(o_tbl_en), .o_tbl_we(o_tbl_we), .o_tbl_addr(o_tbl_addr),
      .o_tbl_wdata(o_tbl_wdata), .i_tbl_rdata(tbl_rdata),
      .o_init_busy(o_init_busy)
   );

   always #5 clk = ~clk;

   // Single-port table: read data is registered, valid the cycle after a read.
   always @(posedge clk) begin
      if (o_tbl_en) begin
         if (o_tbl_we) mem[o_tbl_addr] <= o_tbl_wdata;
         else          tbl_rdata <= mem[o_tbl_addr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] next_ctr(input logic [1:0] c, input logic t);
      if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
      return (c == 2'd0) ? 2'd0 : c - 2'd1;
   endfunction

   // Scoreboard: predictions are queued at grant, and feedback is queued at
   // acceptance. Both are retired against DUT activity.
   always @(negedge clk) begin
      if (mon_en) begin
         if (o_lk_valid) begin
            chk("lk_result_expected", (lkq.size() != 0), 1);
            if (lkq.size() != 0) begin
               mon_t = lkq.pop_front();
               chk("lk_taken", o_lk_taken, mon_t);
            end
         end
         if (o_tbl_en && o_tbl_we) begin
            chk("write_expected", (fbq.size() != 0), 1);
            if (fbq.size() != 0) begin
               mon_h   = fbq.pop_front();
               mon_exp = next_ctr(ref_ctr[mon_h.idx], mon_h.taken);
               chk("upd_wr_addr", o_tbl_addr, mon_h.idx);
               chk("upd_wdata", o_tbl_wdata, mon_exp);
               ref_ctr[mon_h.idx] = mon_exp;
            end
         end else if (o_tbl_en && !o_lk_ready) begin
            chk("upd_read_expected", (fbq.size() != 0), 1);
            if (fbq.size() != 0) chk("upd_rd_addr", o_tbl_addr, fbq[0].idx);
         end
         if (o_lk_ready) begin
            chk("lk_ready_has_valid", i_lk_valid, 1);
            chk("lk_addr", o_tbl_addr, i_lk_index);
            lkq.push_back(ref_ctr[i_lk_index][1]);
         end
         if (i_fb_valid && o_fb_ready) fbq.push_back({i_fb_index, i_fb_taken});
      end
   end

   task automatic drive(input logic lv, input logic [IB-1:0] li,
                        input logic fv, input logic [IB-1:0] fi, input logic ft);
      i_lk_valid = lv; i_lk_index = li;
      i_fb_valid = fv; i_fb_index = fi; i_fb_taken = ft;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic add_vec(input logic lv, input logic [IB-1:0] li, input logic fv,
                          input logic [IB-1:0] fi, input logic ft, input logic er,
                          input logic ef, input logic ee, input logic ew,
                          input logic [IB-1:0] ea, input logic [1:0] ewd);
      vec_t v;
      v.lk_v = lv; v.lk_idx = li; v.fb_v = fv; v.fb_idx = fi; v.fb_t = ft;
      v.e_rdy = er; v.e_fbr = ef; v.e_en = ee; v.e_we = ew; v.e_addr = ea; v.e_wd = ewd;
      vecs.push_back(v);
   endtask

   // Release reset, then watch every sweep cycle while lookups and feedback
   // are offered and must be refused. Called at posedge+1.
   task automatic init_sweep();
      int bad = 0;
      int first_bad = -1;
      rst_n = 1'b1;
      drive(1'b1, 11'h123, 1'b1, 11'd5, 1'b1);
      for (int i = 0; i < N_ENT; i++) begin
         @(negedge clk);
         if (!(o_tbl_en === 1'b1 && o_tbl_we === 1'b1 && o_tbl_addr === IB'(i) &&
               o_tbl_wdata === INITV && o_init_busy === 1'b1 &&
               o_lk_ready === 1'b0 && o_fb_ready === 1'b0)) begin
            bad++;
            if (first_bad < 0) first_bad = i;
         end
         step();
      end
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL init_sweep: %0d bad cycles, first at %0d, required 0 bad", bad, first_bad);
      end
      @(negedge clk);
      chk("busy_after_sweep", o_init_busy, 0);
      chk("idle_en_after_sweep", o_tbl_en, 0);
      chk("fb_ready_after_sweep", o_fb_ready, 1);
      for (int i = 0; i < N_ENT; i++) ref_ctr[i] = INITV;
      step();
      mon_en = 1'b1;
   endtask

   task automatic drain(input string name);
      int n = 0;
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      while ((fbq.size() != 0 || lkq.size() != 0) && n < 50) begin
         step();
         n++;
      end
      step();
      chk({name, "_drained"}, (fbq.size() == 0 && lkq.size() == 0), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Vectors start in RUN with an empty buffer and every counter at 2'b10.
      //       lk idx      fb idx    t   rdy fbr en we addr     wd
      add_vec(1, 11'h123, 0, 0,     0,  1,  1,  1, 0, 11'h123, 0); // v0
      add_vec(0, 0,       0, 0,     0,  0,  1,  0, 0, 0,       0); // v1 idle
      add_vec(1, 11'h7FF, 0, 0,     0,  1,  1,  1, 0, 11'h7FF, 0); // v2 top index
      add_vec(0, 0,       1, 5,     0,  0,  1,  0, 0, 0,       0); // v3 push {5,NT}
      add_vec(0, 0,       0, 0,     0,  0,  1,  1, 0, 5,       0); // v4 read 5
      add_vec(0, 0,       0, 0,     0,  0,  1,  1, 1, 5,       1); // v5 write 01
      add_vec(1, 5,       0, 0,     0,  1,  1,  1, 0, 5,       0); // v6 lookup 5 -> NT
      add_vec(0, 0,       1, 5,     0,  0,  1,  0, 0, 0,       0); // v7 push {5,NT}
      add_vec(1, 11'h10,  0, 0,     0,  1,  1,  1, 0, 11'h10,  0); // v8 lookup beats drain
      add_vec(0, 0,       0, 0,     0,  0,  1,  1, 0, 5,       0); // v9 read 5
      add_vec(0, 0,       0, 0,     0,  0,  1,  1, 1, 5,       0); // v10 write 00
      add_vec(0, 0,       1, 5,     0,  0,  1,  0, 0, 0,       0); // v11 push {5,NT}
      add_vec(0, 0,       0, 0,     0,  0,  1,  1, 0, 5,       0); // v12 read 5
      add_vec(0, 0,       0, 0,     0,  0,  1,  1, 1, 5,       0); // v13 saturate at 00
      add_vec(0, 0,       1, 9,     1,  0,  1,  0, 0, 0,       0); // v14 push {9,T}
      add_vec(0, 0,       0, 0,     0,  0,  1,  1, 0, 9,       0); // v15 read 9
      add_vec(0, 0,       0, 0,     0,  0,  1,  1, 1, 9,       3); // v16 write 11
      add_vec(0, 0,       1, 9,     1,  0,  1,  0, 0, 0,       0); // v17 push {9,T}
      add_vec(0, 0,       0, 0,     0,  0,  1,  1, 0, 9,       0); // v18 read 9
      add_vec(0, 0,       0, 0,     0,  0,  1,  1, 1, 9,       3); // v19 saturate at 11
      add_vec(1, 9,       0, 0,     0,  1,  1,  1, 0, 9,       0); // v20 lookup 9 -> T
      add_vec(1, 5,       0, 0,     0,  1,  1,  1, 0, 5,       0); // v21 lookup 5 -> NT
      add_vec(0, 0,       0, 0,     0,  0,  1,  0, 0, 0,       0); // v22 idle

      // Reset state.
      step(); step();
      @(negedge clk);
      chk("rst_tbl_en", o_tbl_en, 0);
      chk("rst_lk_ready", o_lk_ready, 0);
      chk("rst_fb_ready", o_fb_ready, 0);
      chk("rst_init_busy", o_init_busy, 1);
      chk("rst_lk_valid", o_lk_valid, 0);
      step();

      init_sweep();

      // Table-driven vectors.
      for (int k = 0; k < vecs.size(); k++) begin
         drive(vecs[k].lk_v, vecs[k].lk_idx, vecs[k].fb_v, vecs[k].fb_idx, vecs[k].fb_t);
         @(negedge clk);
         chk($sformatf("v%0d_lk_ready", k), o_lk_ready, vecs[k].e_rdy);
         chk($sformatf("v%0d_fb_ready", k), o_fb_ready, vecs[k].e_fbr);
         chk($sformatf("v%0d_tbl_en", k), o_tbl_en, vecs[k].e_en);
         chk($sformatf("v%0d_tbl_we", k), o_tbl_we, vecs[k].e_we);
         if (vecs[k].e_en) chk($sformatf("v%0d_tbl_addr", k), o_tbl_addr, vecs[k].e_addr);
         if (vecs[k].e_we) chk($sformatf("v%0d_tbl_wdata", k), o_tbl_wdata, vecs[k].e_wd);
         step();
      end
      drain("vectors");

      // Full buffer: lookups held every cycle while four feedbacks arrive.
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, IB'(100 + k), 1'b1, IB'(100 + k), k[0]);
         @(negedge clk);
         chk($sformatf("full_fill%0d_lk_ready", k), o_lk_ready, 1);
         chk($sformatf("full_fill%0d_fb_ready", k), o_fb_ready, 1);
         step();
      end
      drive(1'b1, 11'd104, 1'b1, 11'd104, 1'b1);   // this push must be dropped
      @(negedge clk);
      chk("full_fb_ready", o_fb_ready, 0);
      chk("full_lk_ready", o_lk_ready, 0);
      chk("full_upd_read", {o_tbl_en, o_tbl_we}, 2'b10);
      chk("full_upd_addr", o_tbl_addr, 100);
      step();
      drive(1'b1, 11'd104, 1'b0, '0, 1'b0);
      @(negedge clk);
      chk("full_wr_lk_ready", o_lk_ready, 0);
      chk("full_wr_fb_ready", o_fb_ready, 0);
      chk("full_wr_we", o_tbl_we, 1);
      step();
      @(negedge clk);
      chk("after_full_lk_ready", o_lk_ready, 1);
      chk("after_full_lk_addr", o_tbl_addr, 104);
      step();
      drain("full");

      // Push during UPD_WR at count 2: count holds and order is preserved.
      drive(1'b0, '0, 1'b1, 11'd200, 1'b1);
      @(negedge clk);
      chk("pp_idle_en", o_tbl_en, 0);
      step();
      drive(1'b0, '0, 1'b1, 11'd201, 1'b0);
      @(negedge clk);
      chk("pp_read200", o_tbl_addr, 200);
      step();
      drive(1'b0, '0, 1'b1, 11'd202, 1'b1);
      @(negedge clk);
      chk("pp_updwr_fb_ready", o_fb_ready, 1);
      chk("pp_write200", {o_tbl_we, o_tbl_addr}, {1'b1, 11'd200});
      step();
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      @(negedge clk);
      chk("pp_count_held", dut.fifo_cnt, 2);
      chk("pp_next_head201", o_tbl_addr, 201);
      step();
      drain("pushpop");

      // Reset during UPD_WR: no write, then a full re-sweep with an empty buffer.
      drive(1'b0, '0, 1'b1, 11'd300, 1'b1);
      step();
      drive(1'b0, '0, 1'b0, '0, 1'b0);
      @(negedge clk);
      chk("rmw_read300", {o_tbl_en, o_tbl_we, o_tbl_addr}, {2'b10, 11'd300});
      step();
      mon_en = 1'b0;
      rst_n  = 1'b0;
      drive(1'b1, 11'd300, 1'b1, 11'd301, 1'b1);
      @(negedge clk);
      chk("rst_mid_no_en", o_tbl_en, 0);
      chk("rst_mid_lk_ready", o_lk_ready, 0);
      chk("rst_mid_fb_ready", o_fb_ready, 0);
      chk("rst_mid_busy", o_init_busy, 1);
      step(); step();
      fbq.delete();
      lkq.delete();
      init_sweep();
      chk("fifo_empty_after_reset", dut.fifo_cnt, 0);
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, (k == 0) ? 11'd300 : (k == 1) ? 11'd5 : 11'd9, 1'b0, '0, 1'b0);
         step();
      end
      drive(1'b0, '0, 1'b1, 11'd5, 1'b0);
      step();
      drain("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_predictor_table_scheduler.md
# branch_predictor_table_scheduler

Owns the single read/write port of a branch predictor counter table (2-bit saturating counters) and sequences all traffic on it. Three kinds of traffic share the port:
- fetch-stage prediction lookups;
- buffered execute-stage feedback updates, done as read-modify-write;
- a post-reset sweep that initialises every entry.

It sits between the fetch/execute stages and the predictor storage. This lets the table be a plain single-port RAM instead of a flop array with a multi-thousand-entry reset loop.

## Interface
- INDEX_BITS, 11, table index width (2^INDEX_BITS entries)
- FIFO_DEPTH, 4, feedback buffer entries (power of two, ≥2)
- INIT_VALUE, 2'b10, counter value written by the init sweep (weakly taken)

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_lk_valid  in  1  lookup request
- i_lk_index  in  INDEX_BITS  lookup table index
- o_lk_ready  out  1  lookup granted this cycle
- o_lk_valid  out  1  lookup result valid (one cycle after grant)
- o_lk_taken  out  1  prediction: 1 = TAKEN
- i_fb_valid  in  1  feedback push
- i_fb_index  in  INDEX_BITS  feedback table index
- i_fb_taken  in  1  resolved outcome: 1 = TAKEN
- o_fb_ready  out  1  feedback buffer can accept
- o_tbl_en  out  1  table port enable
- o_tbl_we  out  1  table write enable
- o_tbl_addr  out  INDEX_BITS  table address
- o_tbl_wdata  out  2  table write data
- i_tbl_rdata  in  2  table read data, valid the cycle after a read (en=1, we=0)
- o_init_busy  out  1  init sweep in progress

## Operation
- FSM states: INIT, RUN, UPD_WR.
- **Reset**
  - While rst_n=0:
    - state←INIT, sweep counter←0, FIFO emptied, o_lk_valid←0.
    - o_tbl_en=0, o_lk_ready=0, o_fb_ready=0, o_init_busy=1.
  - Reset in any state, including UPD_WR, aborts the operation. A pending read-modify-write is discarded and the table is re-swept.
- **INIT**
  - Each cycle writes INIT_VALUE to address = sweep counter (en=1, we=1), then increments the counter.
  - After writing address 2^INDEX_BITS−1 → RUN.
  - o_lk_ready=0 and o_fb_ready=0 throughout.
- **RUN** (arbitration, decided combinationally each cycle):
  - FIFO full → update wins.
  - Else i_lk_valid → lookup wins.
  - Else FIFO non-empty → update wins.
  - Else the port is idle (o_tbl_en=0).
  - Lookup grant:
    - o_lk_ready=1; read at i_lk_index.
    - o_lk_valid=1 next cycle, with o_lk_taken=i_tbl_rdata[1].
  - Update grant:
    - Read at FIFO head index; o_lk_ready=0; → UPD_WR.
- **UPD_WR**
  - Write to the head index:
    - i_tbl_rdata+1, saturating at 2'b11, if head outcome is taken;
    - else i_tbl_rdata−1, saturating at 2'b00.
  - Pop the head, o_lk_ready=0, → RUN.
- **Feedback FIFO**
  - Holds {index, taken}.
  - o_fb_ready = !full && state≠INIT. A pop in the same cycle does not raise ready.
  - A push with o_fb_ready=0 is dropped. Upstream must hold, or accept the loss; the table is only a predictor.
  - Push and pop in the same cycle → count unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- **Hazards**
  - No forwarding. A lookup to an index with a buffered update returns the stale counter. This is architecturally permitted.
  - FIFO entries are applied in push order.

## Timing
- **Init:** exactly 2^INDEX_BITS cycles after the first cycle with rst_n=1. o_init_busy drops on the cycle RUN is entered.
- **Lookup:** grant cycle N, result on N+1. Back-to-back lookups sustain one per cycle while the FIFO is not full.
- **Update:** occupies the port for 2 cycles (read, write).
- **Starvation:** worst case for a lookup is 2 cycles per update once the FIFO fills.
- **Registered outputs:** o_lk_valid, state, FIFO.
- **Combinational outputs:** o_tbl_*, o_lk_ready, o_fb_ready, o_lk_taken.

## Test plan
- **Init sweep:** release reset → 2048 consecutive writes of 2'b10 to addresses 0..2047. o_init_busy=1 for exactly those cycles; lookups and feedback not accepted.
- **Lookup after init:** lookup index 0x123 → o_lk_ready same cycle; o_lk_valid=1, o_lk_taken=1 next cycle.
- **Update then lookup:** feedback {index 5, not-taken} with no lookups → read 5, then write 2'b01. A later lookup of 5 returns o_lk_taken=0. A second not-taken writes 2'b00; a third also writes 2'b00 (saturation).
- **Full-FIFO priority:**
  - Push 4 feedbacks while i_lk_valid is held every cycle → o_fb_ready=0 at count 4.
  - The next cycle grants the update, not the lookup.
  - The lookup is granted once the FIFO is no longer full.
- **Simultaneous push/pop:** push during UPD_WR at count 2 → count stays 2; entries are later applied in push order.
- **Reset mid-update:** assert rst_n=0 during UPD_WR → no write issued that cycle. After release, a full re-sweep runs and the FIFO is empty.
